// File: rtl/comm_axil_regs.sv
// AXI4-Lite slave register file for the comm peripheral.
// Independent write/read FSMs, byte strobes, per-register write pulses.
module comm_axil_regs #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH = 32,
   parameter int C_NUM_REGS   = 4
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                         S_AXI_AWPROT,
   input  logic                               S_AXI_AWVALID,
   output logic                               S_AXI_AWREADY,
   input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                               S_AXI_WVALID,
   output logic                               S_AXI_WREADY,
   output logic [1:0]                         S_AXI_BRESP,
   output logic                               S_AXI_BVALID,
   input  logic                               S_AXI_BREADY,
   input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                         S_AXI_ARPROT,
   input  logic                               S_AXI_ARVALID,
   output logic                               S_AXI_ARREADY,
   output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                         S_AXI_RRESP,
   output logic                               S_AXI_RVALID,
   input  logic                               S_AXI_RREADY,
   output logic [C_DATA_WIDTH*C_NUM_REGS-1:0] reg_out,
   output logic [C_NUM_REGS-1:0]              wr_pulse
);

   localparam int IW = $clog2(C_NUM_REGS);
   localparam int NB = C_DATA_WIDTH / 8;

   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_GOT_A = 2'd1;
   localparam logic [1:0] W_GOT_D = 2'd2;
   localparam logic [1:0] W_RESP  = 2'd3;
   localparam logic       R_IDLE  = 1'b0;
   localparam logic       R_RESP  = 1'b1;

   logic [1:0]              wstate_q, wstate_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [IW-1:0]           widx_q, widx_d;
   logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]           wstrb_q, wstrb_d;
   logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
   logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
   logic [C_NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic                    rstate_q, rstate_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                    aw_hs, w_hs, ar_hs, do_wr;
   logic [IW-1:0]           aw_idx, ar_idx, wr_idx;
   logic [C_DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]           wr_strb;
   logic                    unused_ok;

   assign aw_hs  = S_AXI_AWVALID & awready_q;
   assign w_hs   = S_AXI_WVALID & wready_q;
   assign ar_hs  = S_AXI_ARVALID & arready_q;
   assign aw_idx = S_AXI_AWADDR[IW+1:2];
   assign ar_idx = S_AXI_ARADDR[IW+1:2];

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR, S_AXI_ARADDR};

   always_comb begin
      wstate_d  = wstate_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      widx_d    = widx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      do_wr     = 1'b0;
      wr_idx    = aw_idx;
      wr_data   = S_AXI_WDATA;
      wr_strb   = S_AXI_WSTRB;
      case (wstate_q)
         W_IDLE: begin
            // Readies rise here on the first edge out of reset.
            awready_d = 1'b1;
            wready_d  = 1'b1;
            if (aw_hs && w_hs) begin
               do_wr = 1'b1;
            end else if (aw_hs) begin
               widx_d    = aw_idx;
               awready_d = 1'b0;
               wstate_d  = W_GOT_A;
            end else if (w_hs) begin
               wdata_d  = S_AXI_WDATA;
               wstrb_d  = S_AXI_WSTRB;
               wready_d = 1'b0;
               wstate_d = W_GOT_D;
            end
         end
         W_GOT_A: begin
            if (w_hs) begin
               do_wr  = 1'b1;
               wr_idx = widx_q;
            end
         end
         W_GOT_D: begin
            if (aw_hs) begin
               do_wr   = 1'b1;
               wr_data = wdata_q;
               wr_strb = wstrb_q;
            end
         end
         default: begin
            if (S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
      endcase
      if (do_wr) begin
         awready_d = 1'b0;
         wready_d  = 1'b0;
         bvalid_d  = 1'b1;
         wstate_d  = W_RESP;
      end
   end

   always_comb begin
      regs_d     = regs_q;
      wr_pulse_d = '0;
      if (do_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) begin
               regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
         wr_pulse_d[wr_idx] = 1'b1;
      end
   end

   always_comb begin
      rstate_d  = rstate_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (rstate_q == R_IDLE) begin
         arready_d = 1'b1;
         if (ar_hs) begin
            // Pre-edge value: a same-edge write is not visible yet.
            rdata_d   = regs_q[ar_idx];
            rvalid_d  = 1'b1;
            arready_d = 1'b0;
            rstate_d  = R_RESP;
         end
      end else if (S_AXI_RREADY) begin
         rvalid_d  = 1'b0;
         arready_d = 1'b1;
         rstate_d  = R_IDLE;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate_q   <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         widx_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         regs_q     <= '{default: '0};
         wr_pulse_q <= '0;
         rstate_q   <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         wstate_q   <= wstate_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         widx_q     <= widx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         regs_q     <= regs_d;
         wr_pulse_q <= wr_pulse_d;
         rstate_q   <= rstate_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign reg_out[C_DATA_WIDTH*g +: C_DATA_WIDTH] = regs_q[g];
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_comm_axil_regs.sv
// Bench for comm_axil_regs: directed scenarios plus random traffic
// checked against a byte-level register model.
module tb_comm_axil_regs;

   logic         clk = 1'b0;
   logic         areset = 1'b1;
   logic [31:0]  awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [2:0]   awprot = '0, arprot = '0;
   logic [3:0]   wstrb = '0, wr_pulse;
   logic         awvalid = 0, wvalid = 0, bready = 0;
   logic         arvalid = 0, rready = 0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [127:0] reg_out;

   int total = 0;
   int bad = 0;
   logic [31:0] model [4];

   always #5 clk = ~clk;

   comm_axil_regs dut (
      .ACLK(clk), .ARESET(areset),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
      .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   function automatic logic [127:0] model_vec();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) model[i] = '0;
   endfunction

   // Register index is the word address modulo four registers.
   function automatic void model_write(logic [31:0] a, logic [31:0] d,
                                       logic [3:0] s);
      int idx;
      idx = (a / 4) % 4;
      for (int b = 0; b < 4; b++)
         if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly,
                           input int w_dly, output logic ok,
                           output logic [1:0] resp, output logic [3:0] p,
                           output logic [3:0] pn, output int lat);
      logic aw_done, w_done, aw_fire, w_fire;
      int c;
      aw_done = 0; w_done = 0; c = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && c < 60) begin
         if (c == aw_dly) awvalid = 1;
         if (c == w_dly) wvalid = 1;
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(negedge clk);
         c++;
         if (aw_fire) begin awvalid = 0; aw_done = 1; end
         if (w_fire) begin wvalid = 0; w_done = 1; end
      end
      awvalid = 0; wvalid = 0;
      lat = 0;
      while (!bvalid && lat < 60) begin @(negedge clk); lat++; end
      p = wr_pulse;
      resp = bresp;
      ok = aw_done && w_done && bvalid;
      bready = 1;
      @(negedge clk);
      pn = wr_pulse;
      bready = 0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic ok);
      int n, m;
      araddr = a; arvalid = 1; n = 0; m = 0;
      while (!arready && n < 60) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid = 0;
      while (!rvalid && m < 60) begin @(negedge clk); m++; end
      d = rdata; resp = rresp;
      ok = (n < 60) && (m == 0);
      rready = 1;
      @(negedge clk);
      rready = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; logic ok;
      areset = 1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         total++;
         if ({awready, wready, arready, bvalid, rvalid, rdata,
              wr_pulse, reg_out, bresp, rresp} !== '0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d rdy=%b%b%b bv=%b rv=%b regs=%h",
                     i, awready, wready, arready, bvalid, rvalid, reg_out);
         end
      end
      areset = 0;
      model_clear();
      @(negedge clk);
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         bad++;
         $display("FAIL reset_release rdy=%b%b%b want 111",
                  awready, wready, arready);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(i * 4, d, r, ok);
         total++;
         if (!ok || d !== 32'h0 || r !== 2'b00) begin
            bad++;
            $display("FAIL reset_read a=%0h got=%h resp=%b ok=%b want 0",
                     i * 4, d, r, ok);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] vals [4];
      logic [31:0] d; logic [1:0] r; logic ok;
      logic [3:0] p, pn; int lat;
      vals = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
      for (int i = 0; i < 4; i++) begin
         do_write(i * 4, vals[i], 4'hF, 0, 0, ok, r, p, pn, lat);
         model_write(i * 4, vals[i], 4'hF);
         total++;
         if (!ok || lat != 0 || r !== 2'b00) begin
            bad++;
            $display("FAIL basic_b i=%0d ok=%b lat=%0d resp=%b", i, ok, lat, r);
         end
         total++;
         if (p !== (4'b0001 << i) || pn !== 4'b0000) begin
            bad++;
            $display("FAIL basic_pulse i=%0d got=%b,%b want=%b,0000",
                     i, p, pn, 4'b0001 << i);
         end
         do_read(i * 4, d, r, ok);
         total++;
         if (!ok || d !== model[i] || r !== 2'b00) begin
            bad++;
            $display("FAIL basic_read i=%0d got=%h want=%h resp=%b",
                     i, d, model[i], r);
         end
      end
      total++;
      if (reg_out !== {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF}) begin
         bad++;
         $display("FAIL basic_reg_out got=%h", reg_out);
      end
   endtask

   task automatic test_skew();
      logic [31:0] old, nv, d; logic [1:0] r; logic ok, first_rdy;
      for (int ord = 0; ord < 2; ord++) begin
         old = model[1];
         nv = (ord == 0) ? 32'h87654321 : 32'h12345678;
         awaddr = 32'h4; wdata = nv; wstrb = 4'hF;
         if (ord == 0) awvalid = 1; else wvalid = 1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin awvalid = 0; wvalid = 0; end
            first_rdy = (ord == 0) ? awready : wready;
            total++;
            if (bvalid !== 1'b0 || reg_out[63:32] !== old || first_rdy !== 1'b0) begin
               bad++;
               $display("FAIL skew_wait ord=%0d bv=%b reg1=%h want %h rdy=%b",
                        ord, bvalid, reg_out[63:32], old, first_rdy);
            end
         end
         if (ord == 0) wvalid = 1; else awvalid = 1;
         @(negedge clk);
         awvalid = 0; wvalid = 0;
         model_write(32'h4, nv, 4'hF);
         total++;
         if (bvalid !== 1'b1 || reg_out !== model_vec() || wr_pulse !== 4'b0010) begin
            bad++;
            $display("FAIL skew_done ord=%0d bv=%b reg1=%h want %h pulse=%b",
                     ord, bvalid, reg_out[63:32], nv, wr_pulse);
         end
         bready = 1;
         @(negedge clk);
         bready = 0;
         do_read(32'h4, d, r, ok);
         total++;
         if (!ok || d !== nv) begin
            bad++;
            $display("FAIL skew_read ord=%0d got=%h want=%h", ord, d, nv);
         end
      end
   endtask

   task automatic test_strobe_alias();
      logic [1:0] r; logic ok; logic [3:0] p, pn; int lat;
      do_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, ok, r, p, pn, lat);
      model_write(32'h0, 32'hFFFFFFFF, 4'hF);
      do_write(32'h0, 32'h00000000, 4'b0101, 0, 0, ok, r, p, pn, lat);
      model_write(32'h0, 32'h0, 4'b0101);
      total++;
      if (reg_out[31:0] !== 32'hFF00FF00 || reg_out !== model_vec()) begin
         bad++;
         $display("FAIL strobe got=%h want=ff00ff00", reg_out[31:0]);
      end
      do_write(32'h10, 32'h5A5A1234, 4'hF, 0, 0, ok, r, p, pn, lat);
      model_write(32'h10, 32'h5A5A1234, 4'hF);
      total++;
      if (p !== 4'b0001 || reg_out[31:0] !== 32'h5A5A1234) begin
         bad++;
         $display("FAIL alias pulse=%b reg0=%h want 0001 5a5a1234",
                  p, reg_out[31:0]);
      end
      do_write(32'hC, 32'h13572468, 4'b0000, 1, 0, ok, r, p, pn, lat);
      total++;
      if (!ok || lat != 0 || p !== 4'b1000 || reg_out !== model_vec()) begin
         bad++;
         $display("FAIL zero_strb ok=%b pulse=%b regs=%h want %h",
                  ok, p, reg_out, model_vec());
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_r;
      awaddr = 32'hC; wdata = 32'h0BADCAFE; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      araddr = 32'h4; arvalid = 1;
      exp_r = model[1];
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      model_write(32'hC, 32'h0BADCAFE, 4'hF);
      araddr = 32'hC;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (bvalid !== 1 || rvalid !== 1 || rdata !== exp_r ||
             bresp !== 0 || rresp !== 0 ||
             {awready, wready, arready} !== 3'b000) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d bv=%b rv=%b rdata=%h want %h rdy=%b%b%b",
                     i, bvalid, rvalid, rdata, exp_r, awready, wready, arready);
         end
         @(negedge clk);
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
      total++;
      if (rvalid !== 0 || arready !== 1 || bvalid !== 1) begin
         bad++;
         $display("FAIL bp_r_release rv=%b ardy=%b bv=%b", rvalid, arready, bvalid);
      end
      @(negedge clk);
      arvalid = 0;
      total++;
      if (rvalid !== 1 || rdata !== model[3]) begin
         bad++;
         $display("FAIL bp_second_ar rv=%b got=%h want=%h", rvalid, rdata, model[3]);
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
      bready = 1;
      @(negedge clk);
      bready = 0;
      total++;
      if (bvalid !== 0 || awready !== 1 || wready !== 1) begin
         bad++;
         $display("FAIL bp_b_release bv=%b rdy=%b%b", bvalid, awready, wready);
      end
   endtask

   task automatic test_same_edge();
      logic [31:0] old, d; logic [1:0] r; logic ok;
      old = model[2];
      awaddr = 32'h8; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      araddr = 32'h8;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      total++;
      if (rvalid !== 1 || rdata !== old || bvalid !== 1) begin
         bad++;
         $display("FAIL same_edge_old rv=%b got=%h want=%h", rvalid, rdata, old);
      end
      model_write(32'h8, 32'hCAFEF00D, 4'hF);
      rready = 1; bready = 1;
      @(negedge clk);
      rready = 0; bready = 0;
      do_read(32'h8, d, r, ok);
      total++;
      if (!ok || d !== 32'hCAFEF00D) begin
         bad++;
         $display("FAIL same_edge_new got=%h want=cafef00d", d);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d; logic [3:0] s, p, pn, ep;
      logic [1:0] r; logic ok; int lat;
      for (int i = 0; i < 80; i++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                     ok, r, p, pn, lat);
            model_write(a, d, s);
            ep = 4'b0001 << ((a / 4) % 4);
            total++;
            if (!ok || lat != 0 || r !== 0 || p !== ep || pn !== 0 ||
                reg_out !== model_vec()) begin
               bad++;
               $display("FAIL rand_wr i=%0d a=%h ok=%b lat=%0d pulse=%b want %b regs=%h want %h",
                        i, a, ok, lat, p, ep, reg_out, model_vec());
            end
         end else begin
            do_read(a, d, r, ok);
            total++;
            if (!ok || r !== 0 || d !== model[(a / 4) % 4]) begin
               bad++;
               $display("FAIL rand_rd i=%0d a=%h got=%h want=%h",
                        i, a, d, model[(a / 4) % 4]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] d; logic [1:0] r; logic ok;
      awaddr = 32'h8; wdata = $urandom; wstrb = 4'hF;
      araddr = 32'h0;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      total++;
      if (bvalid !== 1 || rvalid !== 1) begin
         bad++;
         $display("FAIL mid_pending bv=%b rv=%b want 1 1", bvalid, rvalid);
      end
      areset = 1;
      @(negedge clk);
      total++;
      if (bvalid !== 0 || rvalid !== 0 || reg_out !== '0 ||
          wr_pulse !== 0 || {awready, wready, arready} !== 3'b000) begin
         bad++;
         $display("FAIL mid_reset bv=%b rv=%b regs=%h pulse=%b",
                  bvalid, rvalid, reg_out, wr_pulse);
      end
      areset = 0;
      model_clear();
      @(negedge clk);
      do_read(32'h8, d, r, ok);
      total++;
      if (!ok || d !== model[2]) begin
         bad++;
         $display("FAIL mid_reset_read ok=%b got=%h want=%h", ok, d, model[2]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skew();
      test_strobe_alias();
      test_backpressure();
      test_same_edge();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
